// File: rtl/seg7_capture_decoder.sv
// -----------------------------------------------------------------------------
// seg7_capture_decoder
//
// Captures active-low 7-segment patterns for a two-digit display, one digit per
// handshaked sample. A digit only commits after STABLE_CYCLES consecutive
// identical accepted samples (same pattern and same slot). The committed pattern
// is decoded back to BCD, and the two digits are assembled into a binary value.
//
// Optional build macro:
//   SEG7_CAPTURE_STICKY_ERR_EN  - seg_err latches on any invalid commit and is
//                                 only cleared by reset.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   seg_in[0:6]  segment pattern, bit 0 = a ... bit 6 = g, 0 = lit
//   seg_idx      digit slot (0 = ones, 1 = tens)
//   seg_valid    sample present
//   seg_ready    block can accept a sample this cycle
//   digit0       committed ones digit (BCD, F = blank, E = invalid)
//   digit1       committed tens digit (same coding)
//   value        digit1*10 + digit0, blank counted as 0
//   frame_valid  one-cycle pulse when a tens commit completes a frame
//   seg_err      invalid-pattern indication
// -----------------------------------------------------------------------------
// state   | meaning
// --------+--------------------------------------------------------------------
// IDLE    | no candidate; next accepted sample starts a new run
// FILTER  | counting consecutive identical samples of the current candidate
// COMMIT  | one cycle: write decoded candidate into its digit slot, not ready
// -----------------------------------------------------------------------------
module seg7_capture_decoder #(
    parameter int unsigned STABLE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [0:6] seg_in,
    input  logic       seg_idx,
    input  logic       seg_valid,
    output logic       seg_ready,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [6:0] value,
    output logic       frame_valid,
    output logic       seg_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILTER = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [3:0] CNT_TGT   = 4'(STABLE_CYCLES);
    localparam logic [3:0] CODE_BLNK = 4'hF;
    localparam logic [3:0] CODE_INV  = 4'hE;

    state_t     state_q, state_d;
    logic [0:6] cand_pat_q, cand_pat_d;
    logic       cand_idx_q, cand_idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] digit0_q, digit0_d;
    logic [3:0] digit1_q, digit1_d;
    logic       seg_err_q, seg_err_d;
    logic       value_upd_q, value_upd_d;
    logic       frame_pend_q, frame_pend_d;
    logic [6:0] value_q, value_d;
    logic       frame_valid_q, frame_valid_d;

    logic [3:0] code;
    logic       xfer;
    logic       match;

    // Blank contributes nothing to the assembled value.
    function automatic logic [6:0] digit_term(input logic [3:0] d);
        return (d == CODE_BLNK) ? 7'd0 : {3'b000, d};
    endfunction

    always_comb begin
        case (cand_pat_q)
            7'b0000001: code = 4'd0;
            7'b1001111: code = 4'd1;
            7'b0010010: code = 4'd2;
            7'b0000110: code = 4'd3;
            7'b1001100: code = 4'd4;
            7'b0100100: code = 4'd5;
            7'b0100000: code = 4'd6;
            7'b0001111: code = 4'd7;
            7'b0000000: code = 4'd8;
            7'b0000100: code = 4'd9;
            7'b1111111: code = CODE_BLNK;
            default:    code = CODE_INV;
        endcase
    end

    // Ready is forced low while reset is held, independent of state.
    assign seg_ready = rst_n && (state_q != ST_COMMIT);
    assign xfer      = seg_valid && seg_ready;
    assign match     = (seg_in == cand_pat_q) && (seg_idx == cand_idx_q);

    always_comb begin
        state_d       = state_q;
        cand_pat_d    = cand_pat_q;
        cand_idx_d    = cand_idx_q;
        cnt_d         = cnt_q;
        digit0_d      = digit0_q;
        digit1_d      = digit1_q;
        seg_err_d     = seg_err_q;
        value_upd_d   = 1'b0;
        frame_pend_d  = 1'b0;
        value_d       = value_q;
        frame_valid_d = frame_pend_q;

        // Value is rebuilt from the registered digits one cycle after a valid
        // commit; an invalid digit in either slot leaves the last result held.
        if (value_upd_q && (digit0_q != CODE_INV) && (digit1_q != CODE_INV)) begin
            value_d = digit_term(digit1_q) * 7'd10 + digit_term(digit0_q);
        end

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    cand_pat_d = seg_in;
                    cand_idx_d = seg_idx;
                    cnt_d      = 4'd1;
                    state_d    = (CNT_TGT == 4'd1) ? ST_COMMIT : ST_FILTER;
                end
            end
            ST_FILTER: begin
                if (xfer) begin
                    if (match) begin
                        cnt_d = (cnt_q >= CNT_TGT) ? cnt_q : cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == CNT_TGT) begin
                            state_d = ST_COMMIT;
                        end
                    end else begin
                        cand_pat_d = seg_in;
                        cand_idx_d = seg_idx;
                        cnt_d      = 4'd1;
                    end
                end
            end
            ST_COMMIT: begin
                if (cand_idx_q) begin
                    digit1_d = code;
                end else begin
                    digit0_d = code;
                end
                if (code == CODE_INV) begin
                    seg_err_d = 1'b1;
                end else begin
`ifdef SEG7_CAPTURE_STICKY_ERR_EN
                    seg_err_d = seg_err_q;
`else
                    seg_err_d = 1'b0;
`endif
                    value_upd_d  = 1'b1;
                    frame_pend_d = cand_idx_q;
                end
                cnt_d   = 4'd0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cand_pat_q    <= 7'b1111111;
            cand_idx_q    <= 1'b0;
            cnt_q         <= 4'd0;
            digit0_q      <= CODE_BLNK;
            digit1_q      <= CODE_BLNK;
            seg_err_q     <= 1'b0;
            value_upd_q   <= 1'b0;
            frame_pend_q  <= 1'b0;
            value_q       <= 7'd0;
            frame_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cand_pat_q    <= cand_pat_d;
            cand_idx_q    <= cand_idx_d;
            cnt_q         <= cnt_d;
            digit0_q      <= digit0_d;
            digit1_q      <= digit1_d;
            seg_err_q     <= seg_err_d;
            value_upd_q   <= value_upd_d;
            frame_pend_q  <= frame_pend_d;
            value_q       <= value_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    assign digit0      = digit0_q;
    assign digit1      = digit1_q;
    assign value       = value_q;
    assign frame_valid = frame_valid_q;
    assign seg_err     = seg_err_q;

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_capture_decoder
//
// Bench for seg7_capture_decoder. A run-length reference model predicts every
// output each cycle; directed sections pin the model with literal values, then
// a randomized phase exercises repeats, gaps, slot changes and resets.
// -----------------------------------------------------------------------------
module tb_seg7_capture_decoder;

    localparam int N = 3;
`ifdef SEG7_CAPTURE_STICKY_ERR_EN
    localparam int STICKY = 1;
`else
    localparam int STICKY = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic [0:6] seg_in;
    logic       seg_idx;
    logic       seg_valid;
    logic       seg_ready;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [6:0] value;
    logic       frame_valid;
    logic       seg_err;

    seg7_capture_decoder #(.STABLE_CYCLES(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .seg_idx     (seg_idx),
        .seg_valid   (seg_valid),
        .seg_ready   (seg_ready),
        .digit0      (digit0),
        .digit1      (digit1),
        .value       (value),
        .frame_valid (frame_valid),
        .seg_err     (seg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [0:6] pats [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100};

    function automatic int decode(input logic [0:6] p);
        if (p == 7'b1111111) return 15;
        for (int i = 0; i < 10; i++) begin
            if (p == pats[i]) return i;
        end
        return 14;
    endfunction

    function automatic int term(input int d);
        return (d == 15) ? 0 : d;
    endfunction

    // Reference model: tracks the current run of identical accepted samples
    // and the delayed effects of a commit.
    int         m_d0 = 15, m_d1 = 15, m_val = 0, m_fv = 0, m_err = 0;
    int         m_run = 0, m_commit = 0, m_vpend = 0, m_fpend = 0;
    logic [0:6] m_pat = 7'b1111111;
    logic       m_idx = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        int c;
        if (!rst_n) begin
            m_d0 = 15; m_d1 = 15; m_val = 0; m_fv = 0; m_err = 0;
            m_run = 0; m_commit = 0; m_vpend = 0; m_fpend = 0;
        end else begin
            m_fv    = m_fpend;
            m_fpend = 0;
            if (m_vpend != 0 && m_d0 != 14 && m_d1 != 14)
                m_val = term(m_d1) * 10 + term(m_d0);
            m_vpend = 0;
            if (m_commit != 0) begin
                c = decode(m_pat);
                if (m_idx) m_d1 = c; else m_d0 = c;
                if (c == 14) begin
                    m_err = 1;
                end else begin
                    if (STICKY == 0) m_err = 0;
                    m_vpend = 1;
                    m_fpend = m_idx ? 1 : 0;
                end
                m_commit = 0;
                m_run    = 0;
            end else if (seg_valid) begin
                if (m_run > 0 && seg_in == m_pat && seg_idx == m_idx) begin
                    m_run = m_run + 1;
                end else begin
                    m_pat = seg_in;
                    m_idx = seg_idx;
                    m_run = 1;
                end
                if (m_run == N) m_commit = 1;
            end
        end
    end

    int tests = 0, fails = 0;
    int fv_cnt = 0, rdy_lo = 0, saw3 = 0;
    logic last_ready = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare against the model at the falling edge, then return
    // just after the next rising edge where the caller may drive new inputs.
    task automatic tick();
        @(negedge clk);
        chk("ready", int'(seg_ready), (rst_n && m_commit == 0) ? 1 : 0);
        chk("digit0", int'(digit0), m_d0);
        chk("digit1", int'(digit1), m_d1);
        chk("value", int'(value), m_val);
        chk("frame_valid", int'(frame_valid), m_fv);
        chk("seg_err", int'(seg_err), m_err);
        last_ready = seg_ready;
        if (frame_valid) fv_cnt++;
        if (rst_n && !seg_ready) rdy_lo++;
        if (digit0 == 4'd3) saw3++;
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [0:6] p, input logic idx);
        int g;
        seg_in    = p;
        seg_idx   = idx;
        seg_valid = 1'b1;
        g = 0;
        do begin
            tick();
            g++;
        end while (!last_ready && g < 20);
        if (!last_ready) chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        seg_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int fv0, rl0, s30, k;
        rst_n = 1'b0; seg_in = 7'b1111111; seg_idx = 1'b0; seg_valid = 1'b0;
        tick();
        chk("rst_ready", int'(seg_ready), 0);
        chk("rst_digit0", int'(digit0), 15);
        chk("rst_digit1", int'(digit1), 15);
        chk("rst_value", int'(value), 0);
        chk("rst_err", int'(seg_err), 0);
        chk("rst_fv", int'(frame_valid), 0);
        tick();
        rst_n = 1'b1;
        idle(2);

        // ones digit 5
        fv0 = fv_cnt;
        for (int i = 0; i < 3; i++) send(7'b0100100, 1'b0);
        idle(4);
        chk("d0_five", int'(digit0), 5);
        chk("val_five", int'(value), 5);
        chk("err_five", int'(seg_err), 0);
        chk("fv_none", fv_cnt - fv0, 0);

        // tens digit 2, valid held across the commit
        fv0 = fv_cnt; rl0 = rdy_lo;
        for (int i = 0; i < 3; i++) send(7'b0010010, 1'b1);
        idle(4);
        chk("d1_two", int'(digit1), 2);
        chk("val_25", int'(value), 25);
        chk("fv_one_cycle", fv_cnt - fv0, 1);
        chk("ready_low_cycles", rdy_lo - rl0, 1);

        // interrupted run: 3,3 discarded, then 1,1,1
        s30 = saw3;
        send(7'b0000110, 1'b0); send(7'b0000110, 1'b0);
        for (int i = 0; i < 3; i++) send(7'b1001111, 1'b0);
        idle(4);
        chk("d0_one", int'(digit0), 1);
        chk("never_three", saw3 - s30, 0);
        chk("val_21", int'(value), 21);

        // invalid then 8
        for (int i = 0; i < 3; i++) send(7'b1010101, 1'b0);
        idle(4);
        chk("d0_inv", int'(digit0), 14);
        chk("err_inv", int'(seg_err), 1);
        chk("val_hold", int'(value), 21);
        for (int i = 0; i < 3; i++) send(7'b0000000, 1'b0);
        idle(4);
        chk("d0_eight", int'(digit0), 8);
        chk("val_28", int'(value), 28);
        chk("err_after", int'(seg_err), STICKY);

        // blank both slots
        fv0 = fv_cnt;
        for (int i = 0; i < 3; i++) send(7'b1111111, 1'b0);
        for (int i = 0; i < 3; i++) send(7'b1111111, 1'b1);
        idle(4);
        chk("blank_d0", int'(digit0), 15);
        chk("blank_d1", int'(digit1), 15);
        chk("blank_val", int'(value), 0);
        chk("blank_fv", fv_cnt - fv0, 1);

        // reset mid-filter
        send(7'b0000000, 1'b0); send(7'b0000000, 1'b0);
        seg_valid = 1'b0;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        send(7'b0000000, 1'b0);
        idle(6);
        chk("rst_mid_d0", int'(digit0), 15);
        chk("rst_mid_d1", int'(digit1), 15);
        chk("rst_mid_val", int'(value), 0);

        // randomized phase
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            seg_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 3) begin
                k = int'($urandom_range(0, 11));
                if (k < 10) seg_in = pats[k];
                else if (k == 10) seg_in = 7'b1111111;
                else seg_in = 7'($urandom_range(0, 127));
                if ($urandom_range(0, 4) == 0) seg_idx = ~seg_idx;
            end
            tick();
        end
        rst_n = 1'b1;
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
